// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants, TX FSM state encoding and baud divisor.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clock cycles per bit; also used by the receive side.
  function automatic int uart_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_baudgen.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_baudgen
// Brief  : Bit-period counter; tick on the last cycle of each bit, held clear while en=0.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_baudgen
  import uart_pkg::*;
#(
  parameter int DIVISOR = 1250
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam int            CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Brief  : 8N1 UART transmitter fed by a small byte FIFO; back-to-back frames.
//          Define UART_TX_PARITY_EN for 8E1 frames (even parity bit after data).
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int              DIVISOR  = uart_divisor(CLK_HZ, BAUD);
  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       tx_nx;
  logic       tick;
  logic       fifo_has_data;

`ifdef UART_TX_PARITY_EN
  logic parity;
`endif

  assign fifo_has_data = (count != '0);
  assign ready         = (count != FULL_CNT);
  assign busy          = (state != ST_IDLE) || fifo_has_data;
  // A write landing on the same edge as a pop still fits, even when full.
  assign push          = wr && (ready || pop);

  uart_tx_baudgen #(
    .DIVISOR(DIVISOR)
  ) u_baudgen (
    .clk (clk),
    .rstn(rstn),
    .en  (state != ST_IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (fifo_has_data) state_nx = ST_START;
      ST_START: if (tick) state_nx = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (tick && bit_idx == LAST_BIT) state_nx = ST_PARITY;
      ST_PARITY: if (tick) state_nx = ST_STOP;
`else
      ST_DATA:   if (tick && bit_idx == LAST_BIT) state_nx = ST_STOP;
`endif
      ST_STOP:  if (tick) state_nx = fifo_has_data ? ST_START : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    tx_nx = tx;
    case (state)
      ST_IDLE: begin
        if (fifo_has_data) begin
          pop   = 1'b1;
          tx_nx = 1'b0;
        end
      end
      ST_START: if (tick) tx_nx = shift[0];
      ST_DATA: begin
        if (tick) begin
`ifdef UART_TX_PARITY_EN
          tx_nx = (bit_idx == LAST_BIT) ? parity : shift[1];
`else
          tx_nx = (bit_idx == LAST_BIT) ? 1'b1 : shift[1];
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) tx_nx = 1'b1;
`endif
      ST_STOP: begin
        if (tick && fifo_has_data) begin
          pop   = 1'b1;
          tx_nx = 1'b0;
        end
      end
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      tx <= tx_nx;
      if (pop) begin
        shift <= mem[rd_ptr];
      end else if (state == ST_DATA && tick) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == ST_START && tick) begin
        bit_idx <= '0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      parity <= 1'b0;
    end else if (pop) begin
      parity <= ^mem[rd_ptr];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_fifo
// Brief  : Directed self-checking bench for uart_tx_fifo (DIVISOR=16).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int BIT_CYC = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = 11 * BIT_CYC;
`else
  localparam int FRAME_CYC = 10 * BIT_CYC;
`endif
  localparam int WAIT_LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       wr = 1'b0;
  logic       ready;
  logic       busy;
  logic       tx;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_fifo #(
    .CLK_HZ    (16),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .data (data),
    .wr   (wr),
    .ready(ready),
    .busy (busy),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v);
    wr   = 1'b1;
    data = v;
    @(negedge clk);
    wr   = 1'b0;
  endtask

  // Finds the start bit, samples mid-bit, returns at the middle of the stop bit.
  // waited = negedges after the first one until tx is seen low.
  task automatic rx_frame(output logic [7:0] b, output logic p, output int waited);
    b = 8'h00;
    p = 1'b0;
    waited = 0;
    @(negedge clk);
    while (tx !== 1'b0 && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("rx_wait_expired", 32'(waited >= WAIT_LIMIT), 0);
    if (waited < WAIT_LIMIT) begin
      repeat (BIT_CYC / 2) @(negedge clk);
      check("rx_start", tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CYC) @(negedge clk);
        b[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (BIT_CYC) @(negedge clk);
      p = tx;
`endif
      repeat (BIT_CYC) @(negedge clk);
      check("rx_stop", tx, 1);
    end
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  logic [7:0] rb;
  logic       rp;
  int         rw;
  logic [7:0] exp_q[$];

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1. Single byte A5: latency, start length, bits, busy drop
    fork
      begin
        wr = 1'b1; data = 8'hA5;
        @(negedge clk);
        wr = 1'b0;
        check("lat_edge1_tx", tx, 1);
        check("lat_edge1_busy", busy, 1);
        check("lat_edge1_ready", ready, 1);
        @(negedge clk);
        check("lat_edge2_tx", tx, 0);
        repeat (BIT_CYC - 1) @(negedge clk);
        check("start_last_cycle", tx, 0);
        @(negedge clk);
        check("bit0_first_cycle", tx, 1);
      end
      begin
        rx_frame(rb, rp, rw);
        check("single_byte", rb, 8'hA5);
      end
    join
    repeat (BIT_CYC / 2 - 1) @(negedge clk);
    check("stop_end_busy", busy, 1);
    @(negedge clk);
    check("after_stop_busy", busy, 0);
    check("after_stop_tx", tx, 1);

    // 2. Back-to-back 00, FF, 55 with no gap
    repeat (5) @(negedge clk);
    exp_q = '{8'h00, 8'hFF, 8'h55};
    fork
      begin push(8'h00); push(8'hFF); push(8'h55); end
      begin
        for (int k = 0; k < 3; k++) begin
          rx_frame(rb, rp, rw);
          check($sformatf("b2b_byte%0d", k), rb, exp_q[k]);
          if (k > 0) check($sformatf("b2b_gap%0d", k), rw, BIT_CYC / 2 - 1);
        end
      end
    join
    idle_quiet("b2b_idle", 40);

    // 3. Full FIFO: 06 dropped
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    fork
      begin
        for (int k = 1; k <= 5; k++) push(8'(k));
        check("full_ready", ready, 0);
        push(8'h06);
        check("full_ready_after_drop", ready, 0);
        check("full_busy", busy, 1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rx_frame(rb, rp, rw);
          check($sformatf("full_byte%0d", k), rb, exp_q[k]);
        end
      end
    join
    idle_quiet("full_no_extra", 3 * FRAME_CYC);

    // 4. Push on the same edge as the STOP->START pop with the FIFO full
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA6};
    fork
      begin
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        repeat (FRAME_CYC - 4) @(negedge clk);
        check("pp_ready_before", ready, 0);
        check("pp_tx_stop", tx, 1);
        push(8'hA6);
        check("pp_ready_after", ready, 0);
        check("pp_tx_start", tx, 0);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          rx_frame(rb, rp, rw);
          check($sformatf("pp_byte%0d", k), rb, exp_q[k]);
        end
      end
    join
    idle_quiet("pp_idle", 2 * FRAME_CYC);

    // 5. Reset during data bit 3 of C3 with two bytes queued
    push(8'hC3); push(8'h11); push(8'h22);
    repeat (4 * BIT_CYC + 6 + 2 - 3) @(negedge clk);
    check("rst_mid_bit3", tx, 0);
    check("rst_mid_ready", ready, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready_after", ready, 1);
    idle_quiet("rst_mid_quiet", 3 * FRAME_CYC);

`ifdef UART_TX_PARITY_EN
    // 6. Even parity bit
    fork
      begin push(8'h07); push(8'h03); end
      begin
        rx_frame(rb, rp, rw);
        check("par_byte07", rb, 8'h07);
        check("par_bit07", rp, 1);
        rx_frame(rb, rp, rw);
        check("par_byte03", rb, 8'h03);
        check("par_bit03", rp, 0);
      end
    join
    idle_quiet("par_idle", 40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
